// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit with a byte-enabled data bus.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses end with err.
module lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  alucode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done_valid,
  output logic [31:0] load_data,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [5:0] ALU_LB  = 6'd11;
  localparam logic [5:0] ALU_LH  = 6'd12;
  localparam logic [5:0] ALU_LW  = 6'd13;
  localparam logic [5:0] ALU_LBU = 6'd14;
  localparam logic [5:0] ALU_LHU = 6'd15;
  localparam logic [5:0] ALU_SB  = 6'd16;
  localparam logic [5:0] ALU_SH  = 6'd17;
  localparam logic [5:0] ALU_SW  = 6'd18;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] cnt;
  logic [5:0]    op;
  logic [1:0]    off;

  logic        is_b, is_h, is_w, is_st;
  logic        misal, go_bus;
  logic [1:0]  eoff;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] lane, ext;
  logic        busy, resp, tmo;

  always_comb begin
    is_b  = 1'b0;
    is_h  = 1'b0;
    is_w  = 1'b0;
    is_st = 1'b0;
    case (alucode)
      ALU_LB, ALU_LBU: is_b = 1'b1;
      ALU_LH, ALU_LHU: is_h = 1'b1;
      ALU_LW:          is_w = 1'b1;
      ALU_SB: begin
        is_b  = 1'b1;
        is_st = 1'b1;
      end
      ALU_SH: begin
        is_h  = 1'b1;
        is_st = 1'b1;
      end
      ALU_SW: begin
        is_w  = 1'b1;
        is_st = 1'b1;
      end
      default: ;
    endcase
  end

  // Lane placement; half/word offsets are aligned down.
  always_comb begin
    eoff = 2'b00;
    be_n = 4'b0000;
    wd_n = 32'h0;
    unique case (1'b1)
      is_b: begin
        eoff = addr[1:0];
        be_n = 4'b0001 << addr[1:0];
        wd_n = {4{wdata[7:0]}};
      end
      is_h: begin
        eoff = {addr[1], 1'b0};
        be_n = addr[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{wdata[15:0]}};
      end
      is_w: begin
        be_n = 4'b1111;
        wd_n = wdata;
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal = (is_h & addr[0])
               | (is_w & (addr[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  assign go_bus = (is_b | is_h | is_w) & ~misal;

  assign lane = mem_rdata >> {off, 3'b000};

  always_comb begin
    ext = mem_rdata;
    case (op)
      ALU_LB:  ext = {{24{lane[7]}}, lane[7:0]};
      ALU_LBU: ext = {24'h0, lane[7:0]};
      ALU_LH:  ext = {{16{lane[15]}}, lane[15:0]};
      ALU_LHU: ext = {16'h0, lane[15:0]};
      default: ext = mem_rdata;
    endcase
  end

  assign busy = (state == REQ) | (state == WAIT);
  assign resp = ((state == REQ) & mem_gnt & mem_rvalid)
              | ((state == WAIT) & mem_rvalid);
  // A response on the last allowed cycle still wins over the abort.
  assign tmo  = busy & ~resp & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (req_valid) state_n = go_bus ? REQ : DONE;
      REQ: begin
        if (resp | tmo)   state_n = DONE;
        else if (mem_gnt) state_n = WAIT;
      end
      WAIT: if (resp | tmo) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    mem_req    = (state == REQ);
    done_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op        <= 6'h0;
      off       <= 2'b00;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0;
      load_data <= 32'h0;
      err       <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        op        <= alucode;
        off       <= eoff;
        cnt       <= '0;
        mem_we    <= is_st;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_be    <= be_n;
        mem_wdata <= wd_n;
        if (!go_bus) begin
          load_data <= 32'h0;
          err       <= misal;
        end
      end
      if (busy) cnt <= cnt + CW'(1);
      if (resp) begin
        load_data <= mem_we ? 32'h0 : ext;
        err       <= 1'b0;
      end else if (tmo) begin
        load_data <= 32'h0;
        err       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: scoreboard bench for lsu (TIMEOUT=8).
// Scenario tasks drive the bus by hand and check completions inline.
module tb_lsu;

  localparam logic [5:0] ALU_LB  = 6'd11;
  localparam logic [5:0] ALU_LH  = 6'd12;
  localparam logic [5:0] ALU_LW  = 6'd13;
  localparam logic [5:0] ALU_LBU = 6'd14;
  localparam logic [5:0] ALU_LHU = 6'd15;
  localparam logic [5:0] ALU_SH  = 6'd17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  alucode = 6'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        done_valid;
  logic [31:0] load_data;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  lsu #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .alucode(alucode), .addr(addr), .wdata(wdata),
    .done_valid(done_valid), .load_data(load_data),
    .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        chk;
  } exp_t;

  exp_t sbq[$];
  exp_t ex;
  int n_checks = 0;
  int n_fail = 0;
  int n_done = 0;

  always @(posedge clk) if (done_valid) n_done++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op,
                       input logic [31:0] a,
                       input logic [31:0] d);
    req_valid = 1'b1;
    alucode = op;
    addr = a;
    wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({req_ready, done_valid, err, mem_req, mem_we} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 10000",
               {req_ready, done_valid, err, mem_req, mem_we});
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (req_ready !== 1'b1 || mem_be !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready_be: got %b %b want 1 0000", req_ready, mem_be);
    end
    n_checks++;
    if ({load_data, mem_addr, mem_wdata} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h want 0",
               load_data, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_lb_fast;
    sbq.push_back('{32'hFFFF_FF80, 1'b0, 1'b1});
    issue(ALU_LB, 32'h103, 32'h0);
    n_checks++;
    if ({mem_req, mem_we, mem_be, req_ready} !== 7'b1010000) begin
      n_fail++;
      $display("FAIL lb_bus: got req=%b we=%b be=%b rdy=%b want 1 0 1000 0",
               mem_req, mem_we, mem_be, req_ready);
    end
    n_checks++;
    if (mem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL lb_addr: got %h want 00000100", mem_addr);
    end
    mem_gnt = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h80FF_FF11;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    n_checks++;
    if (done_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL lb_latency: done_valid got %b want 1 at N+2", done_valid);
    end
    if (sbq.size() > 0) begin
      ex = sbq.pop_front();
      n_checks++;
      if (load_data !== ex.data || err !== ex.err) begin
        n_fail++;
        $display("FAIL lb_result: got %h/%b want %h/%b",
                 load_data, err, ex.data, ex.err);
      end
    end
    tick();
    n_checks++;
    if (done_valid !== 1'b0 || load_data !== 32'hFFFF_FF80) begin
      n_fail++;
      $display("FAIL lb_hold: got dv=%b data=%h want 0 ffffff80",
               done_valid, load_data);
    end
  endtask

  task automatic test_sh_store;
    int nreq;
    int d0;
    nreq = 0;
    sbq.push_back('{32'h0, 1'b0, 1'b0});
    issue(ALU_SH, 32'h202, 32'h1234_ABCD);
    n_checks++;
    if ({mem_we, mem_be} !== 5'b11100 || mem_wdata !== 32'hABCD_ABCD
        || mem_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL sh_bus: got we=%b be=%b wd=%h a=%h want 1 1100 abcdabcd 200",
               mem_we, mem_be, mem_wdata, mem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      nreq += int'(mem_req);
      tick();
    end
    mem_gnt = 1'b1;
    nreq += int'(mem_req);
    tick();
    mem_gnt = 1'b0;
    nreq += int'(mem_req);
    n_checks++;
    if (nreq != 4) begin
      n_fail++;
      $display("FAIL sh_req_cycles: got %0d want 4", nreq);
    end
    d0 = n_done;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    n_checks++;
    if (done_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL sh_done: got %b want 1", done_valid);
    end
    if (sbq.size() > 0) begin
      ex = sbq.pop_front();
      n_checks++;
      if (err !== ex.err) begin
        n_fail++;
        $display("FAIL sh_err: got %b want %b", err, ex.err);
      end
    end
    tick();
    tick();
    n_checks++;
    if (n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL sh_done_count: got %0d want 1", n_done - d0);
    end
  endtask

  task automatic test_load_ext;
    logic [5:0]  ops[6];
    logic [31:0] as[6];
    logic [31:0] rds[6];
    logic [31:0] exps[6];
    ops = '{ALU_LHU, ALU_LH, ALU_LBU, ALU_LB, ALU_LW, ALU_LH};
    as  = '{32'h002, 32'h002, 32'h001, 32'h000, 32'h004, 32'h000};
    rds = '{32'hF00D_0000, 32'hF00D_0000, 32'h0000_8000,
            32'h0000_007F, 32'hDEAD_BEEF, 32'h1234_8765};
    exps = '{32'h0000_F00D, 32'hFFFF_F00D, 32'h0000_0080,
             32'h0000_007F, 32'hDEAD_BEEF, 32'hFFFF_8765};
    for (int i = 0; i < 6; i++) begin
      sbq.push_back('{exps[i], 1'b0, 1'b1});
      issue(ops[i], as[i], 32'h0);
      mem_gnt = 1'b1;
      mem_rdata = ~rds[i];
      tick();
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata = rds[i];
      tick();
      mem_rvalid = 1'b0;
      mem_rdata = 32'h0;
      n_checks++;
      if (done_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL ext%0d_latency: done_valid got %b want 1 at N+3",
                 i, done_valid);
      end
      if (sbq.size() > 0) begin
        ex = sbq.pop_front();
        n_checks++;
        if (load_data !== ex.data || err !== ex.err) begin
          n_fail++;
          $display("FAIL ext%0d_result: got %h/%b want %h/%b",
                   i, load_data, err, ex.data, ex.err);
        end
      end
      tick();
    end
  endtask

  task automatic test_timeout;
    int nreq;
    int d0;
    bit ok;
    nreq = 0;
    ok = 1'b0;
    sbq.push_back('{32'h0, 1'b1, 1'b1});
    issue(ALU_LW, 32'h40, 32'h0);
    for (int i = 0; i < 40; i++) begin
      if (done_valid) begin
        ok = 1'b1;
        break;
      end
      nreq += int'(mem_req);
      tick();
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL tmo_done: got no done_valid in 40 cycles want one");
    end
    n_checks++;
    if (nreq != 8) begin
      n_fail++;
      $display("FAIL tmo_req_cycles: got %0d want 8", nreq);
    end
    if (ok && sbq.size() > 0) begin
      ex = sbq.pop_front();
      n_checks++;
      if (load_data !== ex.data || err !== ex.err) begin
        n_fail++;
        $display("FAIL tmo_result: got %h/%b want %h/%b",
                 load_data, err, ex.data, ex.err);
      end
    end
    tick();
    d0 = n_done;
    mem_gnt = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h5555_5555;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    tick();
    n_checks++;
    if (n_done != d0 || mem_req !== 1'b0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_late_rvalid: got dones=%0d req=%b err=%b want 0 0 1",
               n_done - d0, mem_req, err);
    end
  endtask

  task automatic test_misalign;
    logic [5:0]  ops[2];
    logic [31:0] as[2];
    logic [31:0] rds[2];
    logic [3:0]  bes[2];
    logic [31:0] exps[2];
    ops = '{ALU_LW, ALU_LH};
    as = '{32'h001, 32'h303};
    rds = '{32'h1122_3344, 32'h8001_0000};
    bes = '{4'b1111, 4'b1100};
    exps = '{32'h1122_3344, 32'hFFFF_8001};
    for (int i = 0; i < 2; i++) begin
`ifdef LSU_MISALIGN_TRAP_EN
      sbq.push_back('{32'h0, 1'b1, 1'b1});
      issue(ops[i], as[i], 32'h0);
      n_checks++;
      if (mem_req !== 1'b0 || done_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL mis%0d_trap: got req=%b dv=%b want 0 1",
                 i, mem_req, done_valid);
      end
`else
      sbq.push_back('{exps[i], 1'b0, 1'b1});
      issue(ops[i], as[i], 32'h0);
      n_checks++;
      if (mem_req !== 1'b1 || mem_be !== bes[i]
          || mem_addr !== {as[i][31:2], 2'b00}) begin
        n_fail++;
        $display("FAIL mis%0d_bus: got req=%b be=%b a=%h want 1 %b %h",
                 i, mem_req, mem_be, mem_addr, bes[i],
                 {as[i][31:2], 2'b00});
      end
      mem_gnt = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata = rds[i];
      tick();
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
`endif
      if (sbq.size() > 0) begin
        ex = sbq.pop_front();
        n_checks++;
        if (done_valid !== 1'b1 || load_data !== ex.data || err !== ex.err) begin
          n_fail++;
          $display("FAIL mis%0d_result: got dv=%b %h/%b want 1 %h/%b",
                   i, done_valid, load_data, err, ex.data, ex.err);
        end
      end
      tick();
    end
  endtask

  task automatic test_nonmem;
    sbq.push_back('{32'h0, 1'b0, 1'b1});
    issue(6'd1, 32'h55, 32'h66);
    n_checks++;
    if (mem_req !== 1'b0 || done_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL nonmem_flow: got req=%b dv=%b want 0 1", mem_req, done_valid);
    end
    if (sbq.size() > 0) begin
      ex = sbq.pop_front();
      n_checks++;
      if (load_data !== ex.data || err !== ex.err) begin
        n_fail++;
        $display("FAIL nonmem_result: got %h/%b want %h/%b",
                 load_data, err, ex.data, ex.err);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int nreq;
    sbq.push_back('{32'hFFFF_FFFE, 1'b0, 1'b1});
    sbq.push_back('{32'h0000_00C3, 1'b0, 1'b1});
    issue(ALU_LB, 32'h101, 32'h0);
    req_valid = 1'b1;
    alucode = ALU_LBU;
    addr = 32'h012;
    mem_gnt = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0000_FE00;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (sbq.size() > 0) begin
      ex = sbq.pop_front();
      n_checks++;
      if (done_valid !== 1'b1 || load_data !== ex.data) begin
        n_fail++;
        $display("FAIL b2b_first: got dv=%b %h want 1 %h",
                 done_valid, load_data, ex.data);
      end
    end
    tick();
    nreq = int'(mem_req);
    n_checks++;
    if (req_ready !== 1'b1 || nreq != 0) begin
      n_fail++;
      $display("FAIL b2b_held: got rdy=%b req=%0d want 1 0", req_ready, nreq);
    end
    tick();
    req_valid = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h010 || mem_be !== 4'b0100) begin
      n_fail++;
      $display("FAIL b2b_second_bus: got req=%b a=%h be=%b want 1 010 0100",
               mem_req, mem_addr, mem_be);
    end
    mem_gnt = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h00C3_0000;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (sbq.size() > 0) begin
      ex = sbq.pop_front();
      n_checks++;
      if (done_valid !== 1'b1 || load_data !== ex.data) begin
        n_fail++;
        $display("FAIL b2b_second: got dv=%b %h want 1 %h",
                 done_valid, load_data, ex.data);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid;
    int d0;
    issue(ALU_LW, 32'h80, 32'h0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    d0 = n_done;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h7777_7777;
    tick();
    mem_rvalid = 1'b0;
    n_checks++;
    if ({mem_req, req_ready, done_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL rstmid_ctl: got req=%b rdy=%b dv=%b want 0 1 0",
               mem_req, req_ready, done_valid);
    end
    tick();
    n_checks++;
    if (n_done != d0 || load_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_discard: got dones=%0d data=%h want 0 0",
               n_done - d0, load_data);
    end
  endtask

  initial begin
    test_reset();
    test_lb_fast();
    test_sh_store();
    test_load_ext();
    test_timeout();
    test_misalign();
    test_nonmem();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d left want 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
